// File: rtl/aes_key_expander.sv
// AES-128 round-key sequencer: forward keys 0..10 or, after an in-place
// forward pre-expansion, reverse keys 10..0 using the inverse schedule.
module aes_key_expander #(
    parameter int ROUNDS = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] key_in,
    input  logic         dec,
    output logic [127:0] rk_out,
    output logic [3:0]   rk_round,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic         rk_last,
    output logic         busy,
    output logic         done
);

    if (ROUNDS != 10) begin : g_bad_rounds
        $error("aes_key_expander supports only ROUNDS=10");
    end

    localparam logic [0:2047] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [10:0] idx;
        idx = {x, 3'b000};
        return SBOX_TBL[idx +: 8];
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        logic [7:0] v;
        unique case (r)
            4'd1:    v = 8'h01;
            4'd2:    v = 8'h02;
            4'd3:    v = 8'h04;
            4'd4:    v = 8'h08;
            4'd5:    v = 8'h10;
            4'd6:    v = 8'h20;
            4'd7:    v = 8'h40;
            4'd8:    v = 8'h80;
            4'd9:    v = 8'h1b;
            4'd10:   v = 8'h36;
            default: v = 8'h00;
        endcase
        return v;
    endfunction

    typedef enum logic [1:0] {
        S_IDLE,
        S_PREP,
        S_EMIT
    } state_t;

    state_t       r_state;
    state_t       w_next_state;
    logic [127:0] r_key;
    logic [3:0]   r_round;
    logic         r_dec;
    logic         r_done;

    logic         w_inv;
    logic         w_last;
    logic [31:0]  w_w0, w_w1, w_w2, w_w3;
    logic [31:0]  w_sw_in;
    logic [31:0]  w_rot;
    logic [31:0]  w_sub;
    logic [3:0]   w_ridx;
    logic [31:0]  w_t;
    logic [31:0]  w_n0, w_n1, w_n2, w_n3;
    logic [127:0] w_next_key;

    // One SubWord serves both directions; the inverse feeds it w3^w2,
    // which is the previous round's w3.
    always_comb begin
        w_w0 = r_key[127:96];
        w_w1 = r_key[95:64];
        w_w2 = r_key[63:32];
        w_w3 = r_key[31:0];
        w_inv = (r_state == S_EMIT) && r_dec;
        w_sw_in = w_inv ? (w_w3 ^ w_w2) : w_w3;
        w_rot = {w_sw_in[23:0], w_sw_in[31:24]};
        w_sub = {sbox(w_rot[31:24]), sbox(w_rot[23:16]),
                 sbox(w_rot[15:8]), sbox(w_rot[7:0])};
        w_ridx = w_inv ? r_round : r_round + 4'd1;
        w_t = w_sub ^ {rcon(w_ridx), 24'h0};
        w_n0 = w_w0 ^ w_t;
        w_n1 = w_w1 ^ w_n0;
        w_n2 = w_w2 ^ w_n1;
        w_n3 = w_w3 ^ w_n2;
        if (w_inv) begin
            w_next_key = {w_w0 ^ w_t, w_w1 ^ w_w0,
                          w_w2 ^ w_w1, w_w3 ^ w_w2};
        end else begin
            w_next_key = {w_n0, w_n1, w_n2, w_n3};
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_last = 1'b0;
        if (r_state == S_EMIT) begin
            w_last = r_dec ? (r_round == 4'd0)
                           : (r_round == 4'(ROUNDS));
        end
        unique case (r_state)
            S_IDLE: begin
                if (start) w_next_state = dec ? S_PREP : S_EMIT;
            end
            S_PREP: begin
                if (r_round == 4'(ROUNDS - 1)) w_next_state = S_EMIT;
            end
            S_EMIT: begin
                if (rk_ready && w_last) w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next_state;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_key   <= '0;
            r_round <= '0;
            r_dec   <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_key   <= key_in;
                        r_round <= '0;
                        r_dec   <= dec;
                    end
                end
                S_PREP: begin
                    r_key   <= w_next_key;
                    r_round <= r_round + 4'd1;
                end
                S_EMIT: begin
                    if (rk_ready) begin
                        if (w_last) begin
                            r_done <= 1'b1;
                        end else begin
                            r_key   <= w_next_key;
                            r_round <= r_dec ? r_round - 4'd1
                                             : r_round + 4'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign rk_out   = r_key;
    assign rk_round = r_round;
    assign rk_valid = (r_state == S_EMIT);
    assign rk_last  = w_last;
    assign busy     = (r_state != S_IDLE);
    assign done     = r_done;

endmodule

// File: tb/tb_aes_key_expander.sv
// Bench for aes_key_expander: GF(2^8)-derived key-schedule model,
// per-cycle scoreboard and directed scenarios.
module tb_aes_key_expander;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [127:0] key_in;
    logic         dec;
    logic [127:0] rk_out;
    logic [3:0]   rk_round;
    logic         rk_valid;
    logic         rk_ready;
    logic         rk_last;
    logic         busy;
    logic         done;

    localparam logic [127:0] K1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] K2 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] KZ = 128'h0;

    aes_key_expander #(.ROUNDS(10)) dut (
        .clk(clk), .rst(rst), .start(start), .key_in(key_in),
        .dec(dec), .rk_out(rk_out), .rk_round(rk_round),
        .rk_valid(rk_valid), .rk_ready(rk_ready), .rk_last(rk_last),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a,
                                        input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p ^= a;
            a = xt(a);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] m_sbox(input logic [7:0] a);
        logic [7:0] inv = 8'h00;
        logic [7:0] s;
        for (int y = 1; y < 256; y++)
            if (a != 8'h00 && gmul(a, 8'(y)) == 8'h01) inv = 8'(y);
        s = 8'h63;
        for (int k = 0; k < 5; k++)
            s ^= 8'((inv << k) | (inv >> (8 - k)));
        return s;
    endfunction

    function automatic logic [31:0] subrot(input logic [31:0] w);
        logic [31:0] r;
        r = {w[23:0], w[31:24]};
        return {m_sbox(r[31:24]), m_sbox(r[23:16]),
                m_sbox(r[15:8]), m_sbox(r[7:0])};
    endfunction

    function automatic logic [127:0] model_rk(input logic [127:0] k,
                                              input int r);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = subrot(t) ^ {rc, 24'h0};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endfunction

    logic [127:0] exp_key [$];
    int           exp_rnd [$];
    logic [127:0] obs [$];
    bit           exp_done = 1'b0;

    task automatic load(input logic [127:0] k, input bit d);
        exp_key.delete();
        exp_rnd.delete();
        obs.delete();
        for (int i = 0; i <= 10; i++) begin
            exp_key.push_back(model_rk(k, d ? 10 - i : i));
            exp_rnd.push_back(d ? 10 - i : i);
        end
    endtask

    // Scoreboard: every low phase outside reset
    always @(negedge clk) begin
        if (!rst) begin
            chk("done", 128'(done), 128'(exp_done));
            exp_done = 1'b0;
            if (rk_valid) begin
                if (exp_key.size() == 0) begin
                    chk("spurious_valid", 128'(rk_valid), 128'd0);
                end else begin
                    chk("rk_out", rk_out, exp_key[0]);
                    chk("rk_round", 128'(rk_round), 128'(exp_rnd[0]));
                    chk("rk_last", 128'(rk_last),
                        128'(exp_key.size() == 1));
                    if (rk_ready) begin
                        obs.push_back(rk_out);
                        void'(exp_key.pop_front());
                        void'(exp_rnd.pop_front());
                        if (exp_key.size() == 0) exp_done = 1'b1;
                    end
                end
            end
        end
    end

    task automatic run_start(input logic [127:0] k, input bit d);
        @(posedge clk);
        #1;
        load(k, d);
        start = 1'b1;
        key_in = k;
        dec = d;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic run_wait(input string nm, input int first_exp,
                            input int done_exp);
        int first = 0;
        int n = 1;
        for (n = 1; n <= 200; n++) begin
            @(negedge clk);
            if (rk_valid && first == 0) first = n;
            if (done) break;
        end
        chk({nm, "_first_valid"}, 128'(first), 128'(first_exp));
        chk({nm, "_done_cycle"}, 128'(n), 128'(done_exp));
    endtask

    logic [127:0] enc_obs [$];

    initial begin
        rst = 1'b1;
        start = 1'b0;
        dec = 1'b0;
        key_in = '0;
        rk_ready = 1'b1;
        #12;
        chk("rst_rk_out", rk_out, 128'd0);
        chk("rst_rk_round", 128'(rk_round), 128'd0);
        chk("rst_rk_valid", 128'(rk_valid), 128'd0);
        chk("rst_rk_last", 128'(rk_last), 128'd0);
        chk("rst_busy", 128'(busy), 128'd0);
        chk("rst_done", 128'(done), 128'd0);
        @(negedge clk);
        rst = 1'b0;

        chk("model_k1_r0", model_rk(K1, 0), K1);
        chk("model_k1_r1", model_rk(K1, 1),
            128'ha0fafe1788542cb123a339392a6c7605);
        chk("model_k1_r9", model_rk(K1, 9),
            128'hac7766f319fadc2128d12941575c006e);
        chk("model_k1_r10", model_rk(K1, 10),
            128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        chk("model_k2_r10", model_rk(K2, 10),
            128'h13111d7fe3944a17f307a78b4d2b30c5);
        chk("model_kz_r1", model_rk(KZ, 1),
            128'h62636363626363636263636362636363);

        run_start(K1, 1'b0);
        run_wait("enc_k1", 1, 12);

        run_start(K1, 1'b1);
        run_wait("dec_k1", 11, 22);

        run_start(K1, 1'b0);
        fork
            run_wait("bp_k1", 1, 15);
            begin
                for (int i = 0; i < 50; i++) begin
                    @(posedge clk);
                    #1;
                    if (rk_valid && rk_round == 4'd4) break;
                end
                rk_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1;
                rk_ready = 1'b1;
            end
        join

        run_start(K1, 1'b1);
        fork
            run_wait("ign_k1", 11, 22);
            begin
                repeat (3) @(posedge clk);
                #1;
                start = 1'b1;
                key_in = K2;
                dec = 1'b0;
                @(posedge clk);
                #1;
                start = 1'b0;
                repeat (10) @(posedge clk);
                #1;
                start = 1'b1;
                @(posedge clk);
                #1;
                start = 1'b0;
            end
        join

        run_start(K2, 1'b0);
        fork
            run_wait("lastst_k2", 1, 12);
            begin
                for (int i = 0; i < 50; i++) begin
                    @(negedge clk);
                    if (rk_valid && rk_last) break;
                end
                start = 1'b1;
                key_in = KZ;
                dec = 1'b1;
                @(posedge clk);
                #1;
                start = 1'b0;
            end
        join
        repeat (3) @(negedge clk);
        chk("busy_after_last_start", 128'(busy), 128'd0);

        run_start(K1, 1'b1);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (rk_valid && rk_round == 4'd6) break;
        end
        chk("rst_at_round", 128'(rk_round), 128'd6);
        #2;
        rst = 1'b1;
        exp_key.delete();
        exp_rnd.delete();
        exp_done = 1'b0;
        #1;
        chk("mid_rst_rk_out", rk_out, 128'd0);
        chk("mid_rst_rk_round", 128'(rk_round), 128'd0);
        chk("mid_rst_rk_valid", 128'(rk_valid), 128'd0);
        chk("mid_rst_busy", 128'(busy), 128'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("mid_rst_done", 128'(done), 128'd0);
        end
        rst = 1'b0;
        run_start(K2, 1'b0);
        run_wait("enc_k2", 1, 12);

        run_start(KZ, 1'b0);
        run_wait("enc_kz", 1, 12);
        enc_obs = obs;
        run_start(KZ, 1'b1);
        run_wait("dec_kz", 11, 22);
        chk("kz_enc_count", 128'(enc_obs.size()), 128'd11);
        chk("kz_dec_count", 128'(obs.size()), 128'd11);
        if (enc_obs.size() == 11 && obs.size() == 11) begin
            for (int i = 0; i <= 10; i++)
                chk("kz_reverse", obs[10 - i], enc_obs[i]);
        end

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
